// File: rtl/tdm_demux14_pkg.sv
// tdm_demux14_pkg: shared types and constants for the TDM demultiplexer.
//   state_e : TDM framing FSM states (IDLE, COLLECT)
//   mode_e  : operating mode encodings (addressed / TDM)
//   N_CH    : number of output channels
//   SLOT_W  : width of the TDM slot index
package tdm_demux14_pkg;

  localparam int unsigned N_CH   = 4;
  localparam int unsigned SLOT_W = 2;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_e;

  typedef enum logic {
    MODE_ADDR = 1'b0,
    MODE_TDM  = 1'b1
  } mode_e;

endpackage

// File: rtl/tdm_demux14_if.sv
// tdm_demux14_if: serial input / channel output bundle of tdm_demux14.
//   in, in_valid, sof : serial bit, its qualifier, start-of-frame marker
//   mode, sel         : 0 = addressed (bit goes to out[sel]), 1 = TDM framing
//   clr_err           : clears the sticky frame_err flag
//   out, out_valid    : registered channel values and their update pulse
//   slot              : next TDM slot to be filled
//   frame_err         : sticky framing error
// modport master drives the inputs (source side), slave is the demux.
interface tdm_demux14_if;
  import tdm_demux14_pkg::*;

  logic              in;
  logic              in_valid;
  logic              sof;
  logic              mode;
  logic [SLOT_W-1:0] sel;
  logic              clr_err;
  logic [N_CH-1:0]   out;
  logic              out_valid;
  logic [SLOT_W-1:0] slot;
  logic              frame_err;

  modport master (
    output in, in_valid, sof, mode, sel, clr_err,
    input  out, out_valid, slot, frame_err
  );

  modport slave (
    input  in, in_valid, sof, mode, sel, clr_err,
    output out, out_valid, slot, frame_err
  );

endinterface

// File: rtl/tdm_demux14_slot_ctr.sv
// tdm_slot_ctr: TDM slot counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : force slot to 0 (highest priority)
//   load       : force slot to 1 (start of a new frame)
//   inc        : advance slot by one
//   slot       : current slot index
//   last       : slot is the final slot of the frame
module tdm_slot_ctr
  import tdm_demux14_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load,
  input  logic              inc,
  output logic [SLOT_W-1:0] slot,
  output logic              last
);

  logic [SLOT_W-1:0] slot_q;
  logic [SLOT_W-1:0] slot_d;

  always_comb begin
    slot_d = slot_q;
    if (clr) begin
      slot_d = '0;
    end else if (load) begin
      slot_d = SLOT_W'(1);
    end else if (inc) begin
      slot_d = slot_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot = slot_q;
  assign last = (slot_q == '1);

endmodule

// File: rtl/tdm_demux14.sv
// tdm_demux14: serial-to-4-channel demultiplexer.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : tdm_demux14_if.slave (serial input, mode/sel, channel outputs)
// Addressed mode writes each valid bit straight to out[sel]. TDM mode
// gathers four bits (sof marks the first) into a shadow register and
// publishes them to out atomically when the fourth bit arrives.
// CLR_ON_SOF = 1 zeroes the shadow register on every accepted sof.
module tdm_demux14
  import tdm_demux14_pkg::*;
#(
  parameter bit CLR_ON_SOF = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  tdm_demux14_if.slave bus
);

  state_e            state_q, state_d;
  logic [N_CH-1:0]   shadow_q, shadow_d;
  logic [N_CH-1:0]   out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              err_set;
  logic              slot_clr, slot_load, slot_inc;
  logic [SLOT_W-1:0] slot_cnt;
  logic              slot_last;
  mode_e             mode_s;

  assign mode_s = mode_e'(bus.mode);

  tdm_slot_ctr u_slot_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (slot_clr),
    .load  (slot_load),
    .inc   (slot_inc),
    .slot  (slot_cnt),
    .last  (slot_last)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Addressed mode pins the FSM in IDLE, which is how a
  // mode change aborts a partial frame without raising an error.
  always_comb begin
    state_d = state_q;
    if (mode_s != MODE_TDM) begin
      state_d = IDLE;
    end else if (bus.in_valid) begin
      case (state_q)
        IDLE:    if (bus.sof) state_d = COLLECT;
        COLLECT: if (!bus.sof && slot_last) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output / datapath logic
  always_comb begin
    out_d       = out_q;
    out_valid_d = 1'b0;
    shadow_d    = shadow_q;
    err_set     = 1'b0;
    slot_clr    = 1'b0;
    slot_load   = 1'b0;
    slot_inc    = 1'b0;

    if (mode_s != MODE_TDM) begin
      slot_clr = 1'b1;
      if (bus.in_valid) begin
        out_d[bus.sel] = bus.in;
        out_valid_d    = 1'b1;
      end
    end else if (bus.in_valid) begin
      case (state_q)
        IDLE: begin
          if (bus.sof) begin
            if (CLR_ON_SOF) shadow_d = '0;
            shadow_d[0] = bus.in;
            slot_load   = 1'b1;
          end else begin
            // Orphan bit: dropped, slot stays 0.
            err_set = 1'b1;
          end
        end
        COLLECT: begin
          if (bus.sof) begin
            // Resync: the partial frame is abandoned and this bit starts a new one.
            err_set = 1'b1;
            if (CLR_ON_SOF) shadow_d = '0;
            shadow_d[0] = bus.in;
            slot_load   = 1'b1;
          end else begin
            shadow_d[slot_cnt] = bus.in;
            if (slot_last) begin
              // Publish the completed frame including the bit arriving now.
              out_d       = shadow_d;
              out_valid_d = 1'b1;
              slot_clr    = 1'b1;
            end else begin
              slot_inc = 1'b1;
            end
          end
        end
        default: slot_clr = 1'b1;
      endcase
    end

    // A new error outranks a simultaneous clear.
    frame_err_d = err_set | (frame_err_q & ~bus.clr_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q    <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.slot      = slot_cnt;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_tdm_demux14.sv
// tb_tdm_demux14: directed scenarios plus randomized traffic for tdm_demux14,
// checked every cycle against a frame-queue reference model.
module tb_tdm_demux14;
  import tdm_demux14_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  tdm_demux14_if bus();

  tdm_demux14 #(.CLR_ON_SOF(1'b0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the partial frame is a queue of received bits; its
  // length is the slot index and a non-empty queue means a frame is open.
  logic [3:0] m_out;
  logic       m_vld;
  logic       m_err;
  bit         m_frame[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic verify(input string tag);
    check({tag, ".out"},       32'(bus.out),       32'(m_out));
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(m_vld));
    check({tag, ".slot"},      32'(bus.slot),      32'(m_frame.size()));
    check({tag, ".frame_err"}, 32'(bus.frame_err), 32'(m_err));
  endtask

  task automatic model_step(input bit i, input bit v, input bit s, input bit md,
                            input bit [1:0] sl, input bit clr);
    bit set_err;
    set_err = 1'b0;
    m_vld   = 1'b0;
    if (!md) begin
      m_frame.delete();
      if (v) begin
        m_out[sl] = i;
        m_vld     = 1'b1;
      end
    end else if (v) begin
      if (s) begin
        if (m_frame.size() != 0) set_err = 1'b1;
        m_frame.delete();
        m_frame.push_back(i);
      end else if (m_frame.size() == 0) begin
        set_err = 1'b1;
      end else begin
        m_frame.push_back(i);
        if (m_frame.size() == 4) begin
          for (int k = 0; k < 4; k++) m_out[k] = m_frame[k];
          m_vld = 1'b1;
          m_frame.delete();
        end
      end
    end
    m_err = set_err ? 1'b1 : (clr ? 1'b0 : m_err);
  endtask

  task automatic cycle(input string tag, input bit i, input bit v, input bit s,
                       input bit md, input bit [1:0] sl, input bit clr);
    @(negedge clk);
    bus.in       = i;
    bus.in_valid = v;
    bus.sof      = s;
    bus.mode     = md;
    bus.sel      = sl;
    bus.clr_err  = clr;
    @(posedge clk);
    model_step(i, v, s, md, sl, clr);
    #1;
    verify(tag);
  endtask

  task automatic idle(input string tag, input bit md, input int n);
    for (int k = 0; k < n; k++) cycle(tag, 1'b0, 1'b0, 1'b0, md, 2'd0, 1'b0);
  endtask

  // Asserts reset mid-cycle, checks outputs clear immediately, then releases.
  task automatic do_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    m_out = '0;
    m_vld = 1'b0;
    m_err = 1'b0;
    m_frame.delete();
    verify(tag);
    bus.in_valid = 1'b0;
    bus.clr_err  = 1'b0;
    bus.sof      = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit cur_mode;
    bus.in = 1'b0; bus.in_valid = 1'b0; bus.sof = 1'b0;
    bus.mode = 1'b0; bus.sel = 2'd0; bus.clr_err = 1'b0;
    m_out = '0; m_vld = 1'b0; m_err = 1'b0;

    do_reset("reset0");
    check("reset0.out_const", 32'(bus.out), 32'd0);

    // Addressed writes
    cycle("addr_w2", 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0);
    check("addr_w2.val", 32'(bus.out), 32'b0100);
    cycle("addr_w0", 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
    check("addr_w0.val", 32'(bus.out), 32'b0101);
    idle("addr_gap", 1'b0, 1);
    cycle("addr_clr", 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0);
    cycle("addr_clr0", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);

    // Back-to-back TDM frame
    cycle("tdm_b0", 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0);
    cycle("tdm_b1", 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0);
    cycle("tdm_b2", 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0);
    cycle("tdm_b3", 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0);
    check("tdm.val", 32'(bus.out), 32'b1101);
    idle("tdm_after", 1'b1, 1);

    // Same frame with gaps, preceded by a different frame so 1101 is a change
    cycle("pre_s", 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0);
    for (int k = 0; k < 3; k++) cycle("pre_b", 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0);
    check("pre.val", 32'(bus.out), 32'b0000);
    cycle("gap_b0", 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0);
    idle("gap_i0", 1'b1, 3);
    cycle("gap_b1", 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0);
    idle("gap_i1", 1'b1, 3);
    cycle("gap_b2", 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0);
    idle("gap_i2", 1'b1, 3);
    check("gap.hold", 32'(bus.out), 32'b0000);
    cycle("gap_b3", 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0);
    check("gap.val", 32'(bus.out), 32'b1101);

    // Resync at slot 2
    cycle("rs_a0", 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0);
    cycle("rs_a1", 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0);
    check("rs.slot2", 32'(bus.slot), 32'd2);
    cycle("rs_b0", 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0);
    check("rs.err", 32'(bus.frame_err), 32'd1);
    cycle("rs_b1", 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0);
    cycle("rs_b2", 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0);
    cycle("rs_b3", 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0);
    check("rs.val", 32'(bus.out), 32'b0110);
    cycle("rs_clr", 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1);

    // Orphan bit in IDLE, then clear; then error and clear together
    cycle("orph", 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0);
    check("orph.err", 32'(bus.frame_err), 32'd1);
    idle("orph_hold", 1'b1, 2);
    cycle("orph_clr", 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1);
    check("orph_clr.err", 32'(bus.frame_err), 32'd0);
    cycle("orph_set_wins", 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1);
    cycle("orph_clr2", 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1);

    // Mode change mid-frame aborts silently
    cycle("mc_b0", 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0);
    cycle("mc_b1", 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0);
    idle("mc_addr", 1'b0, 1);
    cycle("mc_orph", 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1);

    // Reset mid-frame
    cycle("rm_b0", 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1);
    cycle("rm_b1", 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0);
    do_reset("rm_reset");
    cycle("rm_f0", 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0);
    cycle("rm_f1", 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0);
    cycle("rm_f2", 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0);
    cycle("rm_f3", 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0);
    check("rm.val", 32'(bus.out), 32'b1110);

    // Randomized traffic
    cur_mode = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(99) < 3) cur_mode = ~cur_mode;
      if ($urandom_range(399) == 0) begin
        do_reset("rnd_reset");
      end else begin
        cycle("rnd",
              1'($urandom_range(1)),
              $urandom_range(99) < 60,
              $urandom_range(99) < 20,
              cur_mode,
              2'($urandom_range(3)),
              $urandom_range(99) < 8);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
